// File: rtl/denoise_pkg.sv
// Shared types and helpers for the denoise frame sequencer.
package denoise_pkg;

   localparam int DEFAULT_CNT_WIDTH = 16;
   localparam int DEFAULT_ERR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_e;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [DEFAULT_ERR_WIDTH-1:0] sat_inc(input logic [DEFAULT_ERR_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/denoise_seq_pos_counter.sv
// Pixel/line position tracker for the sequencer; flags start, end of line and end of frame.
module denoise_seq_pos_counter
   import denoise_pkg::*;
#(
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 adv_i,
   input  logic [CNT_WIDTH-1:0] line_len_i,
   input  logic [CNT_WIDTH-1:0] line_cnt_i,
   output logic                 is_sof_o,
   output logic                 is_eol_o,
   output logic                 is_eof_o
);

   logic [CNT_WIDTH-1:0] x_q, x_d;
   logic [CNT_WIDTH-1:0] y_q, y_d;

   assign is_sof_o = (x_q == '0) && (y_q == '0);
   assign is_eol_o = (x_q == line_len_i - 1'b1);
   assign is_eof_o = is_eol_o && (y_q == line_cnt_i - 1'b1);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (adv_i) begin
         if (is_eol_o) begin
            x_d = '0;
            y_d = is_eof_o ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/denoise_frame_sequencer.sv
// Aligns prev/curr frame streams on SOF and forwards lockstep pixel pairs with regenerated tuser/tlast.
// Optional stall watchdog and timeout_flag port are built when DENOISE_SEQ_TIMEOUT_EN is defined.
module denoise_frame_sequencer
   import denoise_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
   parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
`ifdef DENOISE_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cfg_enable,
   input  logic [CNT_WIDTH-1:0]  cfg_line_len,
   input  logic [CNT_WIDTH-1:0]  cfg_line_cnt,
   input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
   input  logic                  s_prev_axis_tvalid,
   output logic                  s_prev_axis_tready,
   input  logic                  s_prev_axis_tlast,
   input  logic                  s_prev_axis_tuser,
   input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
   input  logic                  s_curr_axis_tvalid,
   output logic                  s_curr_axis_tready,
   input  logic                  s_curr_axis_tlast,
   input  logic                  s_curr_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
   output logic                  m_prev_axis_tvalid,
   input  logic                  m_prev_axis_tready,
   output logic                  m_prev_axis_tlast,
   output logic                  m_prev_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
   output logic                  m_curr_axis_tvalid,
   input  logic                  m_curr_axis_tready,
   output logic                  m_curr_axis_tlast,
   output logic                  m_curr_axis_tuser,
   output logic                  frame_done,
   output logic [ERR_WIDTH-1:0]  sync_err_cnt,
   output logic [ERR_WIDTH-1:0]  line_err_cnt,
   output logic                  cfg_err,
`ifdef DENOISE_SEQ_TIMEOUT_EN
   output logic                  timeout_flag,
`endif
   output logic                  busy
);

   seq_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] line_len_q, line_len_d;
   logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
   logic [ERR_WIDTH-1:0] sync_err_q, sync_err_d;
   logic [ERR_WIDTH-1:0] line_err_q, line_err_d;
   logic                 cfg_err_q, cfg_err_d;

   logic in_sync, in_run, cfg_ok, prev_sof, curr_sof;
   logic both_valid, both_ready, sof_err, fwd_ok, xfer, eol_bad;
   logic is_sof, is_eol, is_eof;
   logic timeout_hit;

   assign in_sync    = (state_q == ST_SYNC);
   assign in_run     = (state_q == ST_RUN);
   assign cfg_ok     = cfg_enable && (cfg_line_len != '0) && (cfg_line_cnt != '0);
   assign prev_sof   = s_prev_axis_tvalid && s_prev_axis_tuser;
   assign curr_sof   = s_curr_axis_tvalid && s_curr_axis_tuser;
   assign both_valid = s_prev_axis_tvalid && s_curr_axis_tvalid;
   assign both_ready = m_prev_axis_tready && m_curr_axis_tready;
   // A stray SOF blocks the pair on both sides so nothing leaks to the core before realignment.
   assign sof_err    = in_run && (prev_sof || curr_sof) && !is_sof;
   assign fwd_ok     = in_run && both_valid && !sof_err;
   assign xfer       = fwd_ok && both_ready;
   assign eol_bad    = (s_prev_axis_tlast != is_eol) || (s_curr_axis_tlast != is_eol);

   denoise_seq_pos_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pos (
      .clk_i      (aclk),
      .rst_i      (areset),
      .clr_i      (!in_run),
      .adv_i      (xfer),
      .line_len_i (line_len_q),
      .line_cnt_i (line_cnt_q),
      .is_sof_o   (is_sof),
      .is_eol_o   (is_eol),
      .is_eof_o   (is_eof)
   );

`ifdef DENOISE_SEQ_TIMEOUT_EN
   logic [31:0] stall_q, stall_d;
   logic        timeout_q, timeout_d;

   assign timeout_hit  = in_run && !xfer && (stall_q == 32'(TIMEOUT_CYCLES - 1));
   assign timeout_flag = timeout_q;

   always_comb begin
      stall_d   = (in_run && !xfer && !timeout_hit) ? stall_q + 32'd1 : '0;
      timeout_d = timeout_q;
      if ((state_q == ST_IDLE) && cfg_ok) timeout_d = 1'b0;
      else if (timeout_hit)               timeout_d = 1'b1;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      line_len_d = line_len_q;
      line_cnt_d = line_cnt_q;
      sync_err_d = sync_err_q;
      line_err_d = line_err_q;
      cfg_err_d  = (state_q == ST_IDLE) && cfg_enable && !cfg_ok;
      case (state_q)
         ST_IDLE: if (cfg_ok) begin
            state_d    = ST_SYNC;
            line_len_d = cfg_line_len;
            line_cnt_d = cfg_line_cnt;
         end
         ST_SYNC: if (!cfg_ok) begin
            state_d = ST_IDLE;
         end else if (prev_sof && curr_sof) begin
            state_d    = ST_RUN;
            line_len_d = cfg_line_len;
            line_cnt_d = cfg_line_cnt;
         end
         ST_RUN: if (sof_err) begin
            sync_err_d = sat_inc(sync_err_q);
            state_d    = ST_SYNC;
         end else if (xfer) begin
            if (eol_bad) line_err_d = sat_inc(line_err_q);
            if (is_eof)  state_d    = cfg_ok ? ST_SYNC : ST_IDLE;
         end else if (timeout_hit) begin
            state_d = ST_SYNC;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         line_len_q <= '0;
         line_cnt_q <= '0;
         sync_err_q <= '0;
         line_err_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_len_q <= line_len_d;
         line_cnt_q <= line_cnt_d;
         sync_err_q <= sync_err_d;
         line_err_q <= line_err_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // In SYNC, non-SOF beats are discarded and an SOF beat is held until the other stream has one too.
   assign s_prev_axis_tready = in_sync ? !prev_sof : xfer;
   assign s_curr_axis_tready = in_sync ? !curr_sof : xfer;

   assign m_prev_axis_tdata  = in_run ? s_prev_axis_tdata : '0;
   assign m_curr_axis_tdata  = in_run ? s_curr_axis_tdata : '0;
   assign m_prev_axis_tvalid = fwd_ok;
   assign m_curr_axis_tvalid = fwd_ok;
   assign m_prev_axis_tuser  = in_run && is_sof;
   assign m_curr_axis_tuser  = in_run && is_sof;
   assign m_prev_axis_tlast  = in_run && is_eol;
   assign m_curr_axis_tlast  = in_run && is_eol;

   assign frame_done   = xfer && is_eof;
   assign sync_err_cnt = sync_err_q;
   assign line_err_cnt = line_err_q;
   assign cfg_err      = cfg_err_q;
   assign busy         = in_sync || in_run;

endmodule

// File: tb/tb_denoise_frame_sequencer.sv
// Randomized scoreboard bench for denoise_frame_sequencer: frames are built as beat lists and the
// expected output pairs are derived from frame geometry alone.
module tb_denoise_frame_sequencer;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct packed {
      logic [31:0] pd;
      logic [31:0] cd;
      logic        u;
      logic        l;
      logic        d;
   } pair_t;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_enable;
   logic [15:0] cfg_line_len, cfg_line_cnt;
   logic [31:0] s_prev_axis_tdata, s_curr_axis_tdata;
   logic        s_prev_axis_tvalid, s_prev_axis_tready, s_prev_axis_tlast, s_prev_axis_tuser;
   logic        s_curr_axis_tvalid, s_curr_axis_tready, s_curr_axis_tlast, s_curr_axis_tuser;
   logic [31:0] m_prev_axis_tdata, m_curr_axis_tdata;
   logic        m_prev_axis_tvalid, m_prev_axis_tready, m_prev_axis_tlast, m_prev_axis_tuser;
   logic        m_curr_axis_tvalid, m_curr_axis_tready, m_curr_axis_tlast, m_curr_axis_tuser;
   logic        frame_done, cfg_err, busy;
   logic [7:0]  sync_err_cnt, line_err_cnt;
`ifdef DENOISE_SEQ_TIMEOUT_EN
   logic        timeout_flag;
`endif

   denoise_frame_sequencer dut (
      .aclk               (aclk),
      .areset             (areset),
      .cfg_enable         (cfg_enable),
      .cfg_line_len       (cfg_line_len),
      .cfg_line_cnt       (cfg_line_cnt),
      .s_prev_axis_tdata  (s_prev_axis_tdata),
      .s_prev_axis_tvalid (s_prev_axis_tvalid),
      .s_prev_axis_tready (s_prev_axis_tready),
      .s_prev_axis_tlast  (s_prev_axis_tlast),
      .s_prev_axis_tuser  (s_prev_axis_tuser),
      .s_curr_axis_tdata  (s_curr_axis_tdata),
      .s_curr_axis_tvalid (s_curr_axis_tvalid),
      .s_curr_axis_tready (s_curr_axis_tready),
      .s_curr_axis_tlast  (s_curr_axis_tlast),
      .s_curr_axis_tuser  (s_curr_axis_tuser),
      .m_prev_axis_tdata  (m_prev_axis_tdata),
      .m_prev_axis_tvalid (m_prev_axis_tvalid),
      .m_prev_axis_tready (m_prev_axis_tready),
      .m_prev_axis_tlast  (m_prev_axis_tlast),
      .m_prev_axis_tuser  (m_prev_axis_tuser),
      .m_curr_axis_tdata  (m_curr_axis_tdata),
      .m_curr_axis_tvalid (m_curr_axis_tvalid),
      .m_curr_axis_tready (m_curr_axis_tready),
      .m_curr_axis_tlast  (m_curr_axis_tlast),
      .m_curr_axis_tuser  (m_curr_axis_tuser),
      .frame_done         (frame_done),
      .sync_err_cnt       (sync_err_cnt),
      .line_err_cnt       (line_err_cnt),
      .cfg_err            (cfg_err),
`ifdef DENOISE_SEQ_TIMEOUT_EN
      .timeout_flag       (timeout_flag),
`endif
      .busy               (busy)
   );

   always #5 aclk = ~aclk;

   beat_t prev_q[$];
   beat_t curr_q[$];
   pair_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    pairs_total = 0;
   int    exp_sync_err = 0;
   int    exp_line_err = 0;
   int    valid_pct = 100;
   int    rdy_pct = 100;
   int    stall_left = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame of L x C pixels; prev may omit its line-end tlast, curr/expected lists may be cut short.
   task automatic push_frame(input int L, input int C, input bit bad_prev_last,
                             input int keep_curr, input int keep_exp);
      logic [31:0] pb = $urandom;
      logic [31:0] cb = $urandom;
      for (int i = 0; i < L * C; i++) begin
         bit eol = ((i % L) == L - 1);
         prev_q.push_back('{data: pb + i, last: eol && !bad_prev_last, user: (i == 0)});
         if (i < keep_curr) curr_q.push_back('{data: cb + i, last: eol, user: (i == 0)});
         if (i < keep_exp) begin
            exp_q.push_back('{pd: pb + i, cd: cb + i, u: (i == 0), l: eol, d: (i == L * C - 1)});
            if (bad_prev_last && eol) exp_line_err++;
         end
      end
   endtask

   task automatic step();
      bit out_xfer, exp_done;
      @(negedge aclk);
      s_prev_axis_tvalid = (prev_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
      s_curr_axis_tvalid = (curr_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
      if (s_prev_axis_tvalid) {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser} = prev_q[0];
      else {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser} = {$urandom, 2'($urandom)};
      if (s_curr_axis_tvalid) {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser} = curr_q[0];
      else {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser} = {$urandom, 2'($urandom)};
      m_prev_axis_tready = ($urandom_range(0, 99) < rdy_pct);
      m_curr_axis_tready = ($urandom_range(0, 99) < rdy_pct);
      if (stall_left > 0) begin
         m_prev_axis_tready = 1'b1;
         m_curr_axis_tready = 1'b0;
         stall_left--;
      end
      #1;
      if (s_prev_axis_tvalid && s_prev_axis_tready) void'(prev_q.pop_front());
      if (s_curr_axis_tvalid && s_curr_axis_tready) void'(curr_q.pop_front());
      out_xfer = m_prev_axis_tvalid && m_prev_axis_tready && m_curr_axis_tvalid && m_curr_axis_tready;
      exp_done = out_xfer && (exp_q.size() > 0) && exp_q[0].d;
      check_eq("frame_done", frame_done, exp_done);
      if (out_xfer) begin
         pairs_total++;
         $display("pair %0d prev=%08h curr=%08h user=%0b/%0b last=%0b/%0b done=%0b", pairs_total,
                  m_prev_axis_tdata, m_curr_axis_tdata, m_prev_axis_tuser, m_curr_axis_tuser,
                  m_prev_axis_tlast, m_curr_axis_tlast, frame_done);
         if (exp_q.size() == 0) begin
            check_eq("pair_unexpected", 1, 0);
         end else begin
            pair_t e = exp_q.pop_front();
            check_eq("pair_data", {m_prev_axis_tdata, m_curr_axis_tdata}, {e.pd, e.cd});
            check_eq("pair_flags", {m_prev_axis_tuser, m_curr_axis_tuser, m_prev_axis_tlast, m_curr_axis_tlast},
                     {e.u, e.u, e.l, e.l});
         end
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((prev_q.size() + curr_q.size() + exp_q.size()) > 0 && n < 3000) begin
         step();
         n++;
      end
      check_eq({tag, "_drained"}, 64'(exp_q.size()), 0);
      prev_q.delete();
      curr_q.delete();
      exp_q.delete();
      repeat (2) step();
   endtask

   task automatic check_counters(input string tag);
      check_eq({tag, "_sync_err"}, sync_err_cnt, exp_sync_err);
      check_eq({tag, "_line_err"}, line_err_cnt, exp_line_err);
   endtask

   initial begin
      int tgt;
      areset = 1'b1;
      cfg_enable = 1'b0;
      cfg_line_len = 16'd4;
      cfg_line_cnt = 16'd2;
      {s_prev_axis_tdata, s_prev_axis_tvalid, s_prev_axis_tlast, s_prev_axis_tuser} = {32'hA5A5_0001, 3'b111};
      {s_curr_axis_tdata, s_curr_axis_tvalid, s_curr_axis_tlast, s_curr_axis_tuser} = {32'h5A5A_0001, 3'b111};
      m_prev_axis_tready = 1'b1;
      m_curr_axis_tready = 1'b1;
      repeat (3) @(negedge aclk);
      check_eq("rst_s_tready", {s_prev_axis_tready, s_curr_axis_tready}, 0);
      check_eq("rst_m_ctrl", {m_prev_axis_tvalid, m_curr_axis_tvalid, m_prev_axis_tuser, m_curr_axis_tuser,
                              m_prev_axis_tlast, m_curr_axis_tlast}, 0);
      check_eq("rst_status", {frame_done, cfg_err, busy, sync_err_cnt, line_err_cnt}, 0);
      areset = 1'b0;
      step();
      check_eq("idle_disabled_busy", busy, 0);

      // Aligned 4x2 frame, everything always ready.
      cfg_enable = 1'b1;
      push_frame(4, 2, 1'b0, 8, 8);
      drain("aligned");
      check_eq("aligned_back_to_sync", busy, 1);
      check_counters("aligned");

      // Random geometries and random valid/ready back-pressure.
      valid_pct = 70;
      rdy_pct = 75;
      for (int b = 0; b < 4; b++) begin
         int L = $urandom_range(1, 5);
         int C = $urandom_range(1, 3);
         cfg_line_len = 16'(L);
         cfg_line_cnt = 16'(C);
         for (int f = 0; f < 2; f++) push_frame(L, C, 1'b0, L * C, L * C);
         drain("random");
      end
      check_counters("random");

      // Junk beats ahead of SOF on prev only.
      cfg_line_len = 16'd4;
      cfg_line_cnt = 16'd2;
      for (int j = 0; j < 3; j++) prev_q.push_back('{data: $urandom, last: 1'($urandom), user: 1'b0});
      push_frame(4, 2, 1'b0, 8, 8);
      drain("junk");
      check_counters("junk");

      // Curr restarts with a new SOF at pixel 5: first frame is cut after 5 pairs.
      push_frame(4, 2, 1'b0, 5, 5);
      push_frame(4, 2, 1'b0, 8, 8);
      exp_sync_err++;
      drain("midsof");
      check_counters("midsof");

      // Ten-cycle stall on m_curr_tready in the middle of the first line.
      valid_pct = 100;
      rdy_pct = 100;
      push_frame(4, 2, 1'b0, 8, 8);
      tgt = pairs_total + 2;
      for (int n = 0; n < 50 && pairs_total < tgt; n++) step();
      stall_left = 10;
      for (int n = 0; n < 10; n++) begin
         step();
         check_eq("stall_s_tready", {s_prev_axis_tready, s_curr_axis_tready}, 0);
         check_eq("stall_m_tvalid", {m_prev_axis_tvalid, m_curr_axis_tvalid}, 2'b11);
         check_eq("stall_data", {m_prev_axis_tdata, m_curr_axis_tdata}, {exp_q[0].pd, exp_q[0].cd});
      end
      drain("stall");

      // Prev omits tlast at both line ends.
      push_frame(4, 2, 1'b1, 8, 8);
      drain("tlast");
      check_counters("tlast");

      // Zero line length with enable held: stays idle and flags the config.
      cfg_enable = 1'b0;
      repeat (3) step();
      cfg_line_len = 16'd0;
      cfg_enable = 1'b1;
      prev_q.push_back('{data: 32'h1234_5678, last: 1'b0, user: 1'b1});
      repeat (3) step();
      check_eq("cfg_err_set", cfg_err, 1);
      check_eq("cfg_err_idle", busy, 0);
      check_eq("cfg_err_no_tready", s_prev_axis_tready, 0);
      prev_q.delete();
      cfg_line_len = 16'd4;
      repeat (2) step();
      check_eq("cfg_err_clear", {cfg_err, busy}, 2'b01);

      // Asynchronous reset at x=2 of a frame.
      push_frame(4, 2, 1'b0, 8, 8);
      tgt = pairs_total + 2;
      for (int n = 0; n < 50 && pairs_total < tgt; n++) step();
      #2;
      areset = 1'b1;
      #1;
      check_eq("arst_s_tready", {s_prev_axis_tready, s_curr_axis_tready}, 0);
      check_eq("arst_m_ctrl", {m_prev_axis_tvalid, m_curr_axis_tvalid, m_prev_axis_tuser, m_curr_axis_tuser,
                               m_prev_axis_tlast, m_curr_axis_tlast, frame_done, busy}, 0);
      check_eq("arst_counters", {sync_err_cnt, line_err_cnt}, 0);
      prev_q.delete();
      curr_q.delete();
      exp_q.delete();
      exp_sync_err = 0;
      exp_line_err = 0;
      repeat (2) step();
      areset = 1'b0;
      push_frame(4, 2, 1'b0, 8, 8);
      drain("post_reset");
      check_counters("post_reset");
      check_eq("post_reset_busy", busy, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/denoise_frame_sequencer.md
Name: denoise_frame_sequencer

Overview:
- Sits between the two input frame streams (previous frame from VDMA read, current frame from capture) and the denoise core.
- Aligns both streams on start-of-frame (tuser) and forwards pixels in lockstep pairs.
- Regenerates tlast/tuser from programmed line length and line count, replacing the manual tuser/count override path.
- Reports frame completion and alignment errors to the register block.

Parameters:
- DATA_WIDTH, 32, pixel word width of all streams
- CNT_WIDTH, 16, width of pixel/line counters and config fields
- ERR_WIDTH, 8, width of saturating error counters
- TIMEOUT_CYCLES, 65535, stall watchdog limit (used only with the optional feature)

Ports:
- aclk  in  1  stream clock
- areset  in  1  asynchronous reset, active-high
- cfg_enable  in  1  run request (from register block)
- cfg_line_len  in  CNT_WIDTH  pixels per line
- cfg_line_cnt  in  CNT_WIDTH  lines per frame
- s_prev_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  previous-frame input
- s_curr_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  current-frame input
- m_prev_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  to core prev port
- m_curr_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  to core curr port
- frame_done  out  1  one-cycle pulse on the last pair of a frame
- sync_err_cnt  out  ERR_WIDTH  saturating count of mid-frame SOF aborts
- line_err_cnt  out  ERR_WIDTH  saturating count of input tlast mismatches
- cfg_err  out  1  high while enabled with a zero line_len or line_cnt
- busy  out  1  high in SYNC or RUN

Behaviour:
- Reset: state IDLE; all tready/tvalid/tlast/tuser = 0; counters, frame_done, cfg_err, busy = 0.
- Latched config: line_len_q and line_cnt_q are captured on IDLE->SYNC and at every frame start; mid-frame cfg writes have no effect.
- FSM IDLE:
  - Both s_*_tready = 0.
  - If cfg_enable and both cfg values are nonzero -> SYNC.
  - If cfg_enable with a zero value -> cfg_err = 1 and remain in IDLE.
- FSM SYNC:
  - Per stream independently: beats with tuser=0 are dropped (tready=1).
  - A beat with tuser=1 is held (tready=0).
  - When both streams hold tuser=1 -> RUN with x=0, y=0, without consuming in the transition cycle.
  - If cfg_enable falls -> IDLE.
- FSM RUN:
  - m_*_tvalid = s_prev_tvalid & s_curr_tvalid.
  - s_*_tready = m_prev_tready & m_curr_tready & both s valid.
  - A pair transfers only when all four handshakes are true in the same cycle. Zero latency, combinational pass-through; tdata is unmodified.
  - m_*_tuser = (x==0 && y==0).
  - m_*_tlast = (x==line_len_q-1).
  - On each pair, x increments; at x==line_len_q-1 it wraps to 0 and y increments.
- Errors in RUN:
  - Either input tuser=1 while not at (0,0): sync_err_cnt += 1 (saturating), nothing is consumed, -> SYNC.
  - Input tlast differs from the expected tlast on either stream: line_err_cnt += 1 (one per pair); the output uses the regenerated tlast.
- Frame end:
  - A pair at x==line_len_q-1 and y==line_cnt_q-1 pulses frame_done.
  - Next state is SYNC if cfg_enable, else IDLE.
  - cfg_enable falling mid-frame takes effect only at frame end.
- Simultaneous events: a SOF error and a tlast mismatch in the same cycle increment only sync_err_cnt.
- Reset mid-frame: immediate return to IDLE; error counters clear.

Optional Feature:
- DENOISE_SEQ_TIMEOUT_EN defined:
  - A stall counter in RUN clears on every pair transfer.
  - When it reaches TIMEOUT_CYCLES, sticky output timeout_flag (1 bit, extra port) is set and the state goes to SYNC.
  - timeout_flag clears only on reset or on the IDLE->SYNC transition.
- Not defined: no counter, no timeout_flag port, RUN waits indefinitely.

Decomposition:
- Package denoise_pkg:
  - state encoding (IDLE=2'd0, SYNC=2'd1, RUN=2'd2)
  - CNT_WIDTH/ERR_WIDTH defaults
  - saturating-increment function
- One sub-module, denoise_seq_pos_counter: holds x/y counters with wrap, and outputs is_sof, is_eol and is_eof.

Test Plan:
- Aligned stream, line_len=4, line_cnt=2, all ready -> 8 pairs, tuser on pair 0, tlast on pairs 3 and 7, frame_done pulse on pair 7, state back to SYNC.
- Prev stream starts with 3 junk beats before SOF -> junk dropped on prev only, curr SOF held, first output pair carries both SOFs, sync_err_cnt=0.
- Curr stream presents tuser at pixel 5 of a 4x2 frame -> sync_err_cnt=1, beat not consumed, realignment on that SOF, next frame output correct.
- m_curr_tready deasserted for 10 cycles mid-line -> no s tready and no counter advance during the stall, both m tvalid held, data unchanged after resume.
- Input tlast missing at x=3 for 2 lines -> line_err_cnt=2, output tlast still at x=3; cfg_line_len=0 with enable -> cfg_err=1, stays IDLE.
- Areset asserted mid-frame at x=2 -> all outputs 0 the same cycle; after release with enable, a full frame sequences correctly (with DENOISE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and curr tvalid held low for 16 cycles -> timeout_flag=1, state SYNC).
